// File: rtl/dcache_controller_pkg.sv
// Package cache_pkg: geometry of the L1 data cache and the FSM state encoding.
// Shared by the interface, the storage sub-module and the controller.
//   ADDR_W      byte-address width
//   NUM_LINES   number of direct-mapped lines (power of two)
//   LINE_BYTES  bytes per line (power of two)
package cache_pkg;

   localparam int ADDR_W     = 32;
   localparam int NUM_LINES  = 16;
   localparam int LINE_BYTES = 32;

   localparam int IDX_W  = $clog2(NUM_LINES);
   localparam int OFF_W  = $clog2(LINE_BYTES);
   localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
   localparam int LINE_W = 8 * LINE_BYTES;
   localparam int WORDS  = LINE_BYTES / 4;
   localparam int WORD_W = $clog2(WORDS);

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_WRITEBACK = 2'd1;
   localparam logic [1:0] ST_ALLOCATE  = 2'd2;

endpackage

// File: rtl/dcache_controller_if.sv
// CPU-side and memory-side bus of the data cache.
//   slave  : cache view (takes CPU requests and memory responses, drives the rest)
//   master : environment view (CPU MEM stage plus data memory)
interface dcache_controller_if;
   import cache_pkg::*;

   logic              cpu_req_i;
   logic              cpu_we_i;
   logic [ADDR_W-1:0] cpu_addr_i;
   logic [31:0]       cpu_wdata_i;
   logic [31:0]       cpu_rdata_o;
   logic              cpu_stall_o;
   logic              mem_req_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [LINE_W-1:0] mem_wdata_o;
   logic [LINE_W-1:0] mem_rdata_i;
   logic              mem_ack_i;

   modport slave (
      input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ack_i,
      output cpu_rdata_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
   );

   modport master (
      output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ack_i,
      input  cpu_rdata_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
   );

endinterface

// File: rtl/dcache_controller_sram.sv
// dcache_sram: tag, valid, dirty and data storage for the direct-mapped cache.
//   clk_i, rst_i          clock, asynchronous active-low reset (clears valid/dirty only)
//   idx_i                 line index shared by the read and write ports
//   rd_*_o                combinational read of the indexed line
//   line_we_i             full-line refill: data and tag written, valid=1, dirty=0
//   word_we_i             single-word store into the indexed line, dirty=1
module dcache_sram
   import cache_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [IDX_W-1:0]  idx_i,
   output logic [TAG_W-1:0]  rd_tag_o,
   output logic              rd_valid_o,
   output logic              rd_dirty_o,
   output logic [LINE_W-1:0] rd_line_o,
   input  logic              line_we_i,
   input  logic [TAG_W-1:0]  line_tag_i,
   input  logic [LINE_W-1:0] line_data_i,
   input  logic              word_we_i,
   input  logic [WORD_W-1:0] word_sel_i,
   input  logic [31:0]       word_data_i
);

   logic [TAG_W-1:0]     tag_r   [NUM_LINES];
   logic [LINE_W-1:0]    data_r  [NUM_LINES];
   logic [NUM_LINES-1:0] valid_r;
   logic [NUM_LINES-1:0] dirty_r;

   assign rd_tag_o   = tag_r[idx_i];
   assign rd_line_o  = data_r[idx_i];
   assign rd_valid_o = valid_r[idx_i];
   assign rd_dirty_o = dirty_r[idx_i];

   // Line status bits; reset invalidates every line so stale tags/data are masked.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         valid_r <= {NUM_LINES{1'b0}};
         dirty_r <= {NUM_LINES{1'b0}};
      end else if (line_we_i) begin
         valid_r[idx_i] <= 1'b1;
         dirty_r[idx_i] <= 1'b0;
      end else if (word_we_i) begin
         dirty_r[idx_i] <= 1'b1;
      end
   end

   // Tag and data arrays; never reset, the valid bit qualifies their contents.
   always_ff @(posedge clk_i) begin
      if (line_we_i) begin
         tag_r[idx_i]  <= line_tag_i;
         data_r[idx_i] <= line_data_i;
      end else if (word_we_i) begin
         data_r[idx_i][{word_sel_i, 5'd0} +: 32] <= word_data_i;
      end
   end

endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped, write-back, write-allocate L1 data cache.
// Word hits are served in the request cycle with no stall. A miss raises
// cpu_stall_o in the same cycle, writes back a dirty victim, refills the line,
// and then the unchanged request hits in IDLE (a store merges at that point).
//   clk_i   clock
//   rst_i   asynchronous active-low reset; abandons any in-flight transfer
//   bus     dcache_controller_if.slave (CPU request/response, memory line bus)
// Geometry comes from cache_pkg.
module dcache_controller
   import cache_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_i,
   dcache_controller_if.slave bus
);

   logic [1:0]        state_r;
   logic [1:0]        state_nxt_s;
   logic [TAG_W-1:0]  tag_s;
   logic [IDX_W-1:0]  idx_s;
   logic [WORD_W-1:0] word_s;
   logic [TAG_W-1:0]  rd_tag_s;
   logic              rd_valid_s;
   logic              rd_dirty_s;
   logic [LINE_W-1:0] rd_line_s;
   logic              hit_s;
   logic              idle_s;
   logic              line_we_s;
   logic              word_we_s;
   logic              unused_s;

   assign tag_s    = bus.cpu_addr_i[ADDR_W-1 -: TAG_W];
   assign idx_s    = bus.cpu_addr_i[OFF_W +: IDX_W];
   assign word_s   = bus.cpu_addr_i[2 +: WORD_W];
   assign unused_s = ^bus.cpu_addr_i[1:0];

   assign hit_s  = bus.cpu_req_i & rd_valid_s & (rd_tag_s == tag_s);
   assign idle_s = (state_r == ST_IDLE);

   // Refill completes on the ack in ALLOCATE; stores only land on an IDLE hit.
   assign line_we_s = (state_r == ST_ALLOCATE) & bus.mem_ack_i;
   assign word_we_s = idle_s & hit_s & bus.cpu_we_i;

   dcache_sram u_sram (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .idx_i       (idx_s),
      .rd_tag_o    (rd_tag_s),
      .rd_valid_o  (rd_valid_s),
      .rd_dirty_o  (rd_dirty_s),
      .rd_line_o   (rd_line_s),
      .line_we_i   (line_we_s),
      .line_tag_i  (tag_s),
      .line_data_i (bus.mem_rdata_i),
      .word_we_i   (word_we_s),
      .word_sel_i  (word_s),
      .word_data_i (bus.cpu_wdata_i)
   );

   // Next-state logic: a miss goes through WRITEBACK only when the victim is dirty.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.cpu_req_i & ~hit_s) begin
               if (rd_valid_s & rd_dirty_s) begin
                  state_nxt_s = ST_WRITEBACK;
               end else begin
                  state_nxt_s = ST_ALLOCATE;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WRITEBACK: begin
            if (bus.mem_ack_i) begin
               state_nxt_s = ST_ALLOCATE;
            end else begin
               state_nxt_s = ST_WRITEBACK;
            end
         end
         ST_ALLOCATE: begin
            if (bus.mem_ack_i) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_ALLOCATE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Output decode. The victim tag is still in the array during WRITEBACK and the
   // CPU address is held stable, so the memory outputs are constant until ack.
   // Outputs are forced low while reset is asserted so the stall drops at once.
   always_comb begin
      bus.cpu_stall_o = 1'b0;
      bus.cpu_rdata_o = 32'd0;
      bus.mem_req_o   = 1'b0;
      bus.mem_we_o    = 1'b0;
      bus.mem_addr_o  = {ADDR_W{1'b0}};
      bus.mem_wdata_o = {LINE_W{1'b0}};
      if (rst_i) begin
         case (state_r)
            ST_IDLE: begin
               bus.cpu_stall_o = bus.cpu_req_i & ~hit_s;
               if (hit_s & ~bus.cpu_we_i) begin
                  bus.cpu_rdata_o = rd_line_s[{word_s, 5'd0} +: 32];
               end else begin
                  bus.cpu_rdata_o = 32'd0;
               end
            end
            ST_WRITEBACK: begin
               bus.cpu_stall_o = 1'b1;
               bus.mem_req_o   = 1'b1;
               bus.mem_we_o    = 1'b1;
               bus.mem_addr_o  = {rd_tag_s, idx_s, {OFF_W{1'b0}}};
               bus.mem_wdata_o = rd_line_s;
            end
            ST_ALLOCATE: begin
               bus.cpu_stall_o = 1'b1;
               bus.mem_req_o   = 1'b1;
               bus.mem_addr_o  = {tag_s, idx_s, {OFF_W{1'b0}}};
            end
            default: begin
               bus.cpu_stall_o = 1'b0;
            end
         endcase
      end else begin
         bus.cpu_stall_o = 1'b0;
         bus.mem_req_o   = 1'b0;
      end
   end

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: table of CPU accesses with expected
// hit/write-back behaviour, a memory model acking 3 cycles into each request,
// a scoreboard of expected memory transactions and load data, and hand-written
// sequences for reset during a refill and a stray ack while idle.
module tb_dcache_controller;
   import cache_pkg::*;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_hit;
      logic        exp_wb;
      logic [31:0] wb_addr;
   } vec_t;

   typedef struct {
      logic              we;
      logic [31:0]       addr;
      logic [LINE_W-1:0] line;
   } memtx_t;

   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   logic              model_ack = 1'b0;
   logic              stray_ack = 1'b0;
   logic [LINE_W-1:0] model_rdata = '0;
   logic [LINE_W-1:0] stray_rdata = '0;

   int errors = 0;
   int checks = 0;

   logic [LINE_W-1:0] bk_mem  [int unsigned];
   logic [LINE_W-1:0] ref_mem [int unsigned];
   memtx_t            exp_mem_q [$];
   logic [31:0]       rd_q [$];

   dcache_controller_if bus();

   assign bus.mem_ack_i   = model_ack | stray_ack;
   assign bus.mem_rdata_i = stray_ack ? stray_rdata : model_rdata;

   dcache_controller u_dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [LINE_W-1:0] pattern_line(input logic [31:0] la);
      logic [LINE_W-1:0] l;
      for (int w = 0; w < WORDS; w++) l[w*32 +: 32] = la + 32'(w * 4) + 32'd5;
      return l;
   endfunction

   function automatic logic [LINE_W-1:0] mem_line(input logic [31:0] la);
      if (bk_mem.exists(la)) return bk_mem[la];
      return pattern_line(la);
   endfunction

   function automatic logic [LINE_W-1:0] ref_line(input logic [31:0] la);
      if (ref_mem.exists(la)) return ref_mem[la];
      return pattern_line(la);
   endfunction

   function automatic logic [31:0] ref_word(input logic [31:0] a);
      logic [LINE_W-1:0] l;
      l = ref_line({a[31:5], 5'd0});
      return l[{a[4:2], 5'd0} +: 32];
   endfunction

   task automatic ref_store(input logic [31:0] a, input logic [31:0] d);
      logic [LINE_W-1:0] l;
      l = ref_line({a[31:5], 5'd0});
      l[{a[4:2], 5'd0} +: 32] = d;
      ref_mem[{a[31:5], 5'd0}] = l;
   endtask

   task automatic do_access(input vec_t v, input string tag);
      logic [31:0] exp_rd;
      int n;
      @(negedge clk_i);
      bus.cpu_req_i   = 1'b1;
      bus.cpu_we_i    = v.we;
      bus.cpu_addr_i  = v.addr;
      bus.cpu_wdata_i = v.wdata;
      if (!v.exp_hit) begin
         if (v.exp_wb) exp_mem_q.push_back('{we: 1'b1, addr: v.wb_addr, line: ref_line(v.wb_addr)});
         exp_mem_q.push_back('{we: 1'b0, addr: {v.addr[31:5], 5'd0}, line: '0});
      end
      if (!v.we) rd_q.push_back(ref_word(v.addr));
      #1;
      chk({tag, "_stall_first"}, LINE_W'(bus.cpu_stall_o), LINE_W'(!v.exp_hit));
      chk({tag, "_memreq_first"}, LINE_W'(bus.mem_req_o), LINE_W'(1'b0));
      n = 0;
      while (bus.cpu_stall_o && n < 60) begin
         @(negedge clk_i);
         #1;
         n++;
      end
      chk({tag, "_stall_end"}, LINE_W'(bus.cpu_stall_o), LINE_W'(1'b0));
      if (!v.we) begin
         exp_rd = rd_q.pop_front();
         chk({tag, "_rdata"}, LINE_W'(bus.cpu_rdata_o), LINE_W'(exp_rd));
      end else begin
         ref_store(v.addr, v.wdata);
      end
      chk({tag, "_memq_drained"}, LINE_W'(exp_mem_q.size()), LINE_W'(0));
      @(posedge clk_i);
      #1;
      bus.cpu_req_i = 1'b0;
   endtask

   initial begin
      vec_t vecs [14];
      vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0,    1'b0, 1'b0, 32'h0};
      vecs[1]  = '{1'b0, 32'h0000_0004, 32'h0,    1'b1, 1'b0, 32'h0};
      vecs[2]  = '{1'b1, 32'h0000_0000, 32'hA,    1'b1, 1'b0, 32'h0};
      vecs[3]  = '{1'b0, 32'h0000_0200, 32'h0,    1'b0, 1'b1, 32'h0000_0000};
      vecs[4]  = '{1'b1, 32'h0000_0404, 32'h1234, 1'b0, 1'b0, 32'h0};
      vecs[5]  = '{1'b0, 32'h0000_0404, 32'h0,    1'b1, 1'b0, 32'h0};
      vecs[6]  = '{1'b0, 32'h0000_0000, 32'h0,    1'b0, 1'b1, 32'h0000_0400};
      vecs[7]  = '{1'b0, 32'h0000_0020, 32'h0,    1'b0, 1'b0, 32'h0};
      vecs[8]  = '{1'b1, 32'h0000_003C, 32'h55,   1'b1, 1'b0, 32'h0};
      vecs[9]  = '{1'b0, 32'h0000_003C, 32'h0,    1'b1, 1'b0, 32'h0};
      vecs[10] = '{1'b0, 32'h0000_01E0, 32'h0,    1'b0, 1'b0, 32'h0};
      vecs[11] = '{1'b0, 32'hFFFF_FFE0, 32'h0,    1'b0, 1'b0, 32'h0};
      vecs[12] = '{1'b0, 32'hFFFF_FFFC, 32'h0,    1'b1, 1'b0, 32'h0};
      vecs[13] = '{1'b0, 32'h0000_01E0, 32'h0,    1'b0, 1'b0, 32'h0};

      bus.cpu_req_i   = 1'b1;
      bus.cpu_we_i    = 1'b0;
      bus.cpu_addr_i  = 32'h0;
      bus.cpu_wdata_i = 32'h0;

      // Memory model: latches and scores each request on its first cycle,
      // checks it is held, acks on the third cycle.
      fork
         begin : mem_model
            int cnt;
            logic              lat_we;
            logic [31:0]       lat_addr;
            logic [LINE_W-1:0] lat_wdata;
            memtx_t            e;
            cnt = 0;
            lat_we = 1'b0;
            lat_addr = 32'h0;
            lat_wdata = '0;
            forever begin
               @(posedge clk_i);
               if (!rst_i) begin
                  cnt = 0;
                  model_ack <= 1'b0;
               end else if (model_ack) begin
                  cnt = 0;
                  model_ack <= 1'b0;
               end else if (bus.mem_req_o) begin
                  if (cnt == 0) begin
                     lat_we    = bus.mem_we_o;
                     lat_addr  = bus.mem_addr_o;
                     lat_wdata = bus.mem_wdata_o;
                     if (exp_mem_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_mem_req: got request we=%0d addr=%0h, expected none", lat_we, lat_addr);
                     end else begin
                        e = exp_mem_q.pop_front();
                        chk("mem_we", LINE_W'(lat_we), LINE_W'(e.we));
                        chk("mem_addr", LINE_W'(lat_addr), LINE_W'(e.addr));
                        if (e.we) chk("mem_wdata", lat_wdata, e.line);
                     end
                  end else begin
                     chk("mem_hold", LINE_W'(bus.mem_we_o == lat_we && bus.mem_addr_o == lat_addr &&
                                            bus.mem_wdata_o == lat_wdata), LINE_W'(1'b1));
                  end
                  if (cnt == 2) begin
                     model_ack <= 1'b1;
                     if (lat_we) bk_mem[lat_addr] = lat_wdata;
                     else model_rdata <= mem_line(lat_addr);
                     cnt = 0;
                  end else begin
                     cnt++;
                  end
               end else begin
                  cnt = 0;
               end
            end
         end
      join_none

      // Reset state, with a request pending to show the stall is held low.
      repeat (3) @(negedge clk_i);
      #1;
      chk("rst_stall", LINE_W'(bus.cpu_stall_o), LINE_W'(1'b0));
      chk("rst_mem_req", LINE_W'(bus.mem_req_o), LINE_W'(1'b0));
      chk("rst_mem_we", LINE_W'(bus.mem_we_o), LINE_W'(1'b0));
      chk("rst_mem_addr", LINE_W'(bus.mem_addr_o), LINE_W'(0));
      chk("rst_mem_wdata", bus.mem_wdata_o, '0);
      chk("rst_rdata", LINE_W'(bus.cpu_rdata_o), LINE_W'(0));
      bus.cpu_req_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b1;

      for (int i = 0; i < 14; i++) do_access(vecs[i], $sformatf("v%0d", i));

      // Reset two cycles into a refill of 0x200 (index 0 holds clean 0x000).
      @(negedge clk_i);
      bus.cpu_req_i  = 1'b1;
      bus.cpu_we_i   = 1'b0;
      bus.cpu_addr_i = 32'h0000_0200;
      exp_mem_q.push_back('{we: 1'b0, addr: 32'h0000_0200, line: '0});
      #1;
      chk("mrst_stall_first", LINE_W'(bus.cpu_stall_o), LINE_W'(1'b1));
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk("mrst_req_before", LINE_W'(bus.mem_req_o), LINE_W'(1'b1));
      rst_i = 1'b0;
      #1;
      chk("mrst_mem_req", LINE_W'(bus.mem_req_o), LINE_W'(1'b0));
      chk("mrst_stall", LINE_W'(bus.cpu_stall_o), LINE_W'(1'b0));
      chk("mrst_mem_addr", LINE_W'(bus.mem_addr_o), LINE_W'(0));
      chk("mrst_q_empty", LINE_W'(exp_mem_q.size()), LINE_W'(0));
      ref_mem = bk_mem;
      bus.cpu_req_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b1;
      do_access('{1'b0, 32'h0000_0200, 32'h0, 1'b0, 1'b0, 32'h0}, "post_rst_200");
      do_access('{1'b0, 32'h0000_003C, 32'h0, 1'b0, 1'b0, 32'h0}, "post_rst_03c");

      // Stray ack with no request: nothing may move or be written.
      @(negedge clk_i);
      stray_rdata = {WORDS{32'hDEAD_BEEF}};
      stray_ack   = 1'b1;
      @(negedge clk_i);
      stray_ack   = 1'b0;
      #1;
      chk("stray_stall", LINE_W'(bus.cpu_stall_o), LINE_W'(1'b0));
      chk("stray_mem_req", LINE_W'(bus.mem_req_o), LINE_W'(1'b0));
      do_access('{1'b0, 32'h0000_0200, 32'h0, 1'b1, 1'b0, 32'h0}, "stray_200");
      do_access('{1'b0, 32'h0000_003C, 32'h0, 1'b1, 1'b0, 32'h0}, "stray_03c");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
